sub_seq: RTL and testbench
==========================

# sub_seq

Multi-cycle subtractor computing `minuend - subtrahend - bin` over `WIDTH` bits. It processes `CHUNK` bits per clock with a registered borrow chain, which keeps the critical path to one `CHUNK`-bit subtract. It is the subtract-direction counterpart to the arithmetic library's combinational adders, for datapaths that trade latency for area and timing. It has valid/ready handshakes on input and output and accepts one operation at a time.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a positive multiple of `CHUNK`; violations are an elaboration error.
- `CHUNK`, default 8: bits processed per cycle. N = `WIDTH`/`CHUNK` processing cycles.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands and `bin` are valid.
- `in_ready` output 1: block is idle and will accept.
- `minuend` input `WIDTH`: operand A.
- `subtrahend` input `WIDTH`: operand B.
- `bin` input 1: borrow-in, subtracted at the LSB.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output `WIDTH`: (A - B - `bin`) mod 2^`WIDTH`.
- `bout` output 1: borrow-out, 1 iff A < B + `bin` (unsigned).
- `ovf` output 1: signed overflow, defined as A[msb] != B[msb] && `diff`[msb] != A[msb].
- `zero` output 1: `diff` == 0.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: capture A, B into internal registers, borrow register ← `bin`, chunk index ← 0, go to BUSY.
  - Without `in_valid`, stay in IDLE.
- **BUSY**
  - Each cycle, chunk i = A[i*CHUNK +: CHUNK] - B[i*CHUNK +: CHUNK] - borrow is written into the working register. The borrow register takes that chunk's borrow, and the index increments.
  - After the chunk with index N-1, go to DONE.
  - `in_ready` = 0. `in_valid` and operand pins are ignored; captured operands are unaffected by pin changes after acceptance.
- **DONE**
  - On the edge entering DONE, `diff`, `bout`, `ovf` and `zero` are loaded from the working register and final borrow, and `out_valid` is set.
  - On `out_valid && out_ready`: `out_valid` ← 0, go to IDLE.
  - Without `out_ready`, hold indefinitely. Outputs stay stable and no new operation is accepted.
- **Output stability:** `diff`, `bout`, `ovf` and `zero` change only on entry to DONE. They retain their last values otherwise, including after the handshake.
- **`bin` handling:** `bin` is a full borrow-in. `bin`=1 with B = 2^`WIDTH`-1 yields `bout`=1 for any A.
- **Reset:** `rst_n` low at any time, including mid-BUSY or in DONE, immediately aborts.
  - In-flight data is discarded.
  - State goes to IDLE; index and borrow go to 0.

## Timing
- **Reset values:** `in_ready`=0, `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0, `zero`=1.
- **After reset release:** `in_ready` rises after the first rising edge with `rst_n` high. `in_ready` is registered and equals (state == IDLE).
- **Accept to result:** if acceptance occurs at edge E, `out_valid` is high after edge E+N. CHUNK = WIDTH gives a 1-cycle latency.
- **Result to next accept:** an output handshake at edge F makes `in_ready` high after F. The earliest next accept is F+1.
- **Throughput:** max one operation per N+2 cycles.
- **No combinational paths:** there is no combinational path from `in_valid` or `out_ready` to any output.

## Test plan
Defaults throughout: WIDTH=32, CHUNK=8, N=4.
- **Basic subtract:** A=0x00000005, B=0x00000003, `bin`=0.
  - Required: `diff`=0x00000002, `bout`=0, `ovf`=0, `zero`=0.
  - `out_valid` rises exactly 4 cycles after accept.
- **Unsigned underflow:** A=0x00000000, B=0x00000001, `bin`=0.
  - Required: `diff`=0xFFFFFFFF, `bout`=1, `ovf`=0.
  - The borrow propagates across all 4 chunks.
- **Signed overflow:** A=0x80000000, B=0x00000001, `bin`=0.
  - Required: `diff`=0x7FFFFFFF, `bout`=0, `ovf`=1.
- **Borrow-in to zero:** A=0x12345678, B=0x12345677, `bin`=1.
  - Required: `diff`=0x00000000, `zero`=1, `bout`=0.
  - Follow with A=0, B=0xFFFFFFFF, `bin`=1. Required: `diff`=0x00000000, `bout`=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`, while driving `in_valid`=1 with new operands.
  - Required: `out_valid` stays high, `diff` and flags are stable, `in_ready`=0, and no new operation is accepted.
  - Then `out_ready`=1 for one cycle. Required: `out_valid` drops, and `in_ready`=1 next cycle.
- **Reset mid-operation:** assert `rst_n`=0 two cycles into BUSY.
  - Required: outputs take their reset values asynchronously.
  - After release, A=0x00000100, B=0x00000001, `bin`=0 must yield `diff`=0x000000FF, `bout`=0, with no residue from the aborted operation.

Source files
------------

// File: rtl/sub_seq.sv
`default_nettype none
// ============================================================================
// Module  : sub_seq
// Brief   : Multi-cycle subtractor, CHUNK bits per clock with registered borrow.
// Revision: 1.0 - initial release
// ============================================================================
module sub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_N     = WIDTH / CHUNK;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    if (WIDTH <= 0 || CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("sub_seq: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 a_msb_q;
    logic                 b_msb_q;
    logic                 borrow_q;
    logic [c_IDX_W-1:0]   idx_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     diff_q;
    logic                 bout_q;
    logic                 ovf_q;
    logic                 zero_q;

    logic [CHUNK:0]       w_sub;
    logic [WIDTH-1:0]     w_work_next;

    // Operands shift right each cycle, so the current chunk is always the low CHUNK bits.
    assign w_sub = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                 - {{CHUNK{1'b0}}, borrow_q};

    if (c_N == 1) begin : g_single
        assign w_work_next = w_sub[CHUNK-1:0];
    end else begin : g_multi
        logic [WIDTH-CHUNK-1:0] work_q;

        assign w_work_next = {w_sub[CHUNK-1:0], work_q};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                work_q <= '0;
            end else if (state_q == S_BUSY) begin
                work_q <= w_work_next[WIDTH-1:CHUNK];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            borrow_q    <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_q        <= minuend;
                        b_q        <= subtrahend;
                        a_msb_q    <= minuend[WIDTH-1];
                        b_msb_q    <= subtrahend[WIDTH-1];
                        borrow_q   <= bin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    a_q      <= a_q >> CHUNK;
                    b_q      <= b_q >> CHUNK;
                    borrow_q <= w_sub[CHUNK];
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == c_LAST) begin
                        diff_q      <= w_work_next;
                        bout_q      <= w_sub[CHUNK];
                        ovf_q       <= (a_msb_q != b_msb_q) && (w_sub[CHUNK-1] != a_msb_q);
                        zero_q      <= (w_work_next == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sub_seq
// Brief   : Scoreboard bench for sub_seq at WIDTH=32, CHUNK=8.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sub_seq;

    localparam int c_N = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        b;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] minuend = '0;
    logic [31:0] subtrahend = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    sub_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .bout       (bout),
        .ovf        (ovf),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
        exp_t e;
        e.d = a - b - {31'b0, bi};
        e.b = ({2'b0, a} < ({2'b0, b} + {33'b0, bi}));
        e.o = (a[31] != b[31]) && (e.d[31] != a[31]);
        e.z = (e.d == 32'h0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, "_diff"}, diff, e.d);
        chk({tag, "_bout"}, {31'b0, bout}, {31'b0, e.b});
        chk({tag, "_ovf"},  {31'b0, ovf},  {31'b0, e.o});
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, e.z});
    endtask

    // Accept one operation, garble pins while busy, optionally stall the output.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input int stall);
        exp_t e;
        int   lat;
        wait_ready();
        minuend    = a;
        subtrahend = b;
        bin        = bi;
        in_valid   = 1'b1;
        sb.push_back(model(a, b, bi));
        tick();
        minuend    = $urandom;
        subtrahend = $urandom;
        bin        = 1'($urandom);
        chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, c_N);
        e = sb.pop_front();
        chk_result("result", e);
        for (int i = 0; i < stall; i++) begin
            minuend    = $urandom;
            subtrahend = $urandom;
            tick();
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk_result("stall", e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_out_valid", {31'b0, out_valid}, 32'd0);
        chk("hs_in_ready", {31'b0, in_ready}, 32'd1);
        chk_result("post_hs", e);
        if (stall > 0) begin
            for (int i = 0; i < c_N + 2; i++) begin
                tick();
                chk("no_accept", {31'b0, out_valid}, 32'd0);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  {31'b0, in_ready},  32'd0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_diff"},      diff,               32'd0);
        chk({tag, "_bout"},      {31'b0, bout},      32'd0);
        chk({tag, "_ovf"},       {31'b0, ovf},       32'd0);
        chk({tag, "_zero"},      {31'b0, zero},      32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        chk("rel_in_ready_low", {31'b0, in_ready}, 32'd0);
        tick();
        chk("rel_in_ready_high", {31'b0, in_ready}, 32'd1);

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 0);
        run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 10);

        // Abort two cycles into BUSY, after a result with nonzero diff is visible.
        wait_ready();
        minuend    = 32'hFFFF_0000;
        subtrahend = 32'h0000_FFFF;
        bin        = 1'b1;
        in_valid   = 1'b1;
        sb.push_back(model(32'hFFFF_0000, 32'h0000_FFFF, 1'b1));
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        sb.delete();
        tick();
        rst_n = 1'b1;
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, 1'($urandom), 0);
        end
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
